// File: rtl/pw_entry_fsm.sv
// Four-press push-button password FSM feeding the character display (OUT) and LED timer control.
// Define PW_LOCKOUT_EN to add the LOCK state entered after MAX_FAIL consecutive failed entries.
module pw_entry_fsm #(
  parameter logic [1:0]  PW0            = 2'd0,
  parameter logic [1:0]  PW1            = 2'd1,
  parameter logic [1:0]  PW2            = 2'd3,
  parameter logic [1:0]  PW3            = 2'd2,
  parameter int unsigned HOLD_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned LOCK_CYCLES    = 1_000_000_000,
  parameter int unsigned MAX_FAIL       = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [4:0] OUT,
  output logic       ledoff,
  output logic       unlocked,
  output logic       locked
);

  localparam int unsigned MAX_HT = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
`ifdef PW_LOCKOUT_EN
  typedef enum logic [2:0] {IDLE, ENTRY, OPEN, FAIL, LOCK} state_t;
  localparam int unsigned MAX_T = (LOCK_CYCLES > MAX_HT) ? LOCK_CYCLES : MAX_HT;
  localparam int          FW    = (MAX_FAIL < 1) ? 1 : $clog2(MAX_FAIL + 1);
`else
  typedef enum logic [2:0] {IDLE, ENTRY, OPEN, FAIL} state_t;
  localparam int unsigned MAX_T = MAX_HT;
`endif
  localparam int TW = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] HOLD_LAST    = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
`ifdef PW_LOCKOUT_EN
  localparam logic [TW-1:0] LOCK_LAST    = TW'(LOCK_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_SAT     = FW'(MAX_FAIL);
  logic [FW-1:0] fail_cnt;
`endif

  state_t        state;
  logic [2:0]    digit_cnt;
  logic          mismatch;
  logic [TW-1:0] timer;
  logic [3:0]    level, prev, press;
  logic          armed;
  logic          press_any, multi, miss_now;
  logic [1:0]    idx, expected;

  // armed stays low for the first cycle after reset so a button held through reset is not a press.
  assign level     = {d, c, b, a};
  assign press     = armed ? (level & ~prev) : 4'b0000;
  assign press_any = |press;
  assign multi     = (press & (press - 4'd1)) != 4'd0;
  assign miss_now  = multi || (idx != expected);

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (press[i]) idx = 2'(i);
    end
    case (digit_cnt)
      3'd1:    expected = PW1;
      3'd2:    expected = PW2;
      3'd3:    expected = PW3;
      default: expected = PW0;
    endcase
  end

  // Display bundle {OUT, ledoff, unlocked} for the state being entered.
  function automatic logic [6:0] disp(state_t s, logic [2:0] cnt);
    case (s)
      ENTRY:   return {2'b00, cnt, 1'b0, 1'b0};
      OPEN:    return {5'd20, 1'b1, 1'b1};
      FAIL:    return {5'd21, 1'b1, 1'b0};
`ifdef PW_LOCKOUT_EN
      LOCK:    return {5'd22, 1'b1, 1'b0};
`endif
      default: return 7'd0;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, and every register is reset.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      digit_cnt               <= 3'd0;
      mismatch                <= 1'b0;
      timer                   <= '0;
      prev                    <= 4'b0000;
      armed                   <= 1'b0;
      {OUT, ledoff, unlocked} <= 7'd0;
`ifdef PW_LOCKOUT_EN
      fail_cnt                <= '0;
      locked                  <= 1'b0;
`endif
    end else begin
      prev  <= level;
      armed <= 1'b1;
      case (state)
        IDLE: if (press_any) begin
          state                   <= ENTRY;
          digit_cnt               <= 3'd1;
          mismatch                <= miss_now;
          timer                   <= '0;
          {OUT, ledoff, unlocked} <= disp(ENTRY, 3'd1);
        end
        ENTRY: if (press_any) begin
          timer <= '0;
          if (digit_cnt == 3'd3) begin
            digit_cnt <= 3'd0;
            mismatch  <= 1'b0;
            if (mismatch || miss_now) begin
              state                   <= FAIL;
              {OUT, ledoff, unlocked} <= disp(FAIL, 3'd0);
`ifdef PW_LOCKOUT_EN
              if (fail_cnt != FAIL_SAT) fail_cnt <= fail_cnt + FW'(1);
`endif
            end else begin
              state                   <= OPEN;
              {OUT, ledoff, unlocked} <= disp(OPEN, 3'd0);
`ifdef PW_LOCKOUT_EN
              fail_cnt                <= '0;
`endif
            end
          end else begin
            digit_cnt               <= digit_cnt + 3'd1;
            mismatch                <= mismatch | miss_now;
            {OUT, ledoff, unlocked} <= disp(ENTRY, digit_cnt + 3'd1);
          end
        end else if (timer == TIMEOUT_LAST) begin
          state                   <= IDLE;
          digit_cnt               <= 3'd0;
          mismatch                <= 1'b0;
          timer                   <= '0;
          {OUT, ledoff, unlocked} <= disp(IDLE, 3'd0);
        end else begin
          timer <= timer + TW'(1);
        end
        OPEN, FAIL: if (timer == HOLD_LAST) begin
          timer <= '0;
`ifdef PW_LOCKOUT_EN
          if (state == FAIL && fail_cnt == FAIL_SAT) begin
            state                   <= LOCK;
            locked                  <= 1'b1;
            {OUT, ledoff, unlocked} <= disp(LOCK, 3'd0);
          end else
`endif
          begin
            state                   <= IDLE;
            {OUT, ledoff, unlocked} <= disp(IDLE, 3'd0);
          end
        end else begin
          timer <= timer + TW'(1);
        end
`ifdef PW_LOCKOUT_EN
        LOCK: if (timer == LOCK_LAST) begin
          state                   <= IDLE;
          timer                   <= '0;
          fail_cnt                <= '0;
          locked                  <= 1'b0;
          {OUT, ledoff, unlocked} <= disp(IDLE, 3'd0);
        end else begin
          timer <= timer + TW'(1);
        end
`endif
        default: begin
          state                   <= IDLE;
          digit_cnt               <= 3'd0;
          mismatch                <= 1'b0;
          timer                   <= '0;
          {OUT, ledoff, unlocked} <= 7'd0;
        end
      endcase
    end
  end

`ifndef PW_LOCKOUT_EN
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pw_entry_fsm.sv
// Self-checking bench for pw_entry_fsm with small timing parameters and a cycle-level
// reference model of the password rules (works with or without PW_LOCKOUT_EN).
module tb_pw_entry_fsm;

  localparam int HOLD    = 8;
  localparam int TIMEOUT = 20;
  localparam int LOCKC   = 30;
  localparam int MAXF    = 3;
  localparam int PW [4]  = '{0, 1, 3, 2};
`ifdef PW_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic       clkin = 1'b0;
  logic       reset;
  logic       a, b, c, d;
  logic [4:0] OUT;
  logic       ledoff, unlocked, locked;

  pw_entry_fsm #(
    .PW0(2'd0), .PW1(2'd1), .PW2(2'd3), .PW3(2'd2),
    .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT),
    .LOCK_CYCLES(LOCKC), .MAX_FAIL(MAXF)
  ) dut (
    .clkin(clkin), .reset(reset),
    .a(a), .b(b), .c(c), .d(d),
    .OUT(OUT), .ledoff(ledoff), .unlocked(unlocked), .locked(locked)
  );

  always #5 clkin = ~clkin;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference model: digits entered so far, whether any was wrong, idle gap,
  // remaining display cycles for the current result code, and consecutive failures.
  logic [3:0] m_prev;
  bit         m_armed;
  int         m_digits, m_gap, m_show, m_code, m_fails;
  bit         m_bad;

  task automatic model_reset();
    m_prev = 4'b0; m_armed = 1'b0; m_digits = 0; m_gap = 0;
    m_show = 0; m_code = 0; m_fails = 0; m_bad = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] lvl);
    logic [3:0] pr;
    int n, k;
    pr = m_armed ? (lvl & ~m_prev) : 4'b0;
    m_prev  = lvl;
    m_armed = 1'b1;
    n = $countones(pr);
    if (m_show > 0) begin
      m_show--;
      if (m_show == 0) begin
        if (LOCKOUT && m_code == 21 && m_fails == MAXF) begin
          m_code = 22; m_show = LOCKC;
        end else begin
          if (m_code == 22) m_fails = 0;
          m_code = 0;
        end
      end
    end else if (n > 0) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (pr[i]) k = i;
      if (n > 1 || k != PW[m_digits]) m_bad = 1'b1;
      m_digits++;
      m_gap = 0;
      if (m_digits == 4) begin
        m_code = m_bad ? 21 : 20;
        m_show = HOLD;
        if (m_bad) begin
          if (m_fails < MAXF) m_fails++;
        end else begin
          m_fails = 0;
        end
        m_digits = 0;
        m_bad    = 1'b0;
      end
    end else if (m_digits > 0) begin
      m_gap++;
      if (m_gap == TIMEOUT) begin
        m_digits = 0; m_bad = 1'b0; m_gap = 0;
      end
    end
  endtask

  function automatic logic [7:0] expected_out();
    logic       show;
    logic [4:0] o;
    show = (m_show > 0);
    o = show ? 5'(m_code) : 5'(m_digits);
    return {o, show, show && m_code == 20, show && m_code == 22};
  endfunction

  function automatic logic [7:0] observed_out();
    return {OUT, ledoff, unlocked, locked};
  endfunction

  // Drive one cycle of button levels (bit0=a .. bit3=d) and advance the model.
  task automatic cycle(input logic [3:0] lvl);
    {d, c, b, a} = lvl;
    @(posedge clkin);
    model_step(lvl);
    @(negedge clkin);
    cyc++;
  endtask

  task automatic test_reset();
    tests_run++;
    if (observed_out() !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want 00", observed_out());
    end
    reset = 1'b0;
    cycle(4'b0000);
    tests_run++;
    if (observed_out() !== expected_out()) begin
      tests_failed++;
      $display("FAIL reset_release: got %h want %h", observed_out(), expected_out());
    end
  endtask

  task automatic test_open();
    logic [3:0] q[$];
    q = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
    repeat (HOLD + 3) q.push_back(4'b0000);
    foreach (q[i]) begin
      cycle(q[i]);
      tests_run++;
      if (observed_out() !== expected_out()) begin
        tests_failed++;
        $display("FAIL open cycle %0d: got %h want %h", cyc, observed_out(), expected_out());
      end
      if ((i == 3 && (OUT !== 5'd20 || unlocked !== 1'b1)) || (i == 3 + HOLD && OUT !== 5'd0)) begin
        tests_failed++;
        $display("FAIL open_fixed step %0d: got OUT=%0d unlocked=%b", i, OUT, unlocked);
      end
      if (i == 3 || i == 3 + HOLD) tests_run++;
    end
  endtask

  task automatic test_wrong();
    logic [3:0] q[$];
    q = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0100};
    repeat (HOLD + 2) q.push_back(4'b0000);
    foreach (q[i]) begin
      cycle(q[i]);
      tests_run++;
      if (observed_out() !== expected_out()) begin
        tests_failed++;
        $display("FAIL wrong cycle %0d: got %h want %h", cyc, observed_out(), expected_out());
      end
      if (i == 6) begin
        tests_run++;
        if (OUT !== 5'd21 || unlocked !== 1'b0 || ledoff !== 1'b1) begin
          tests_failed++;
          $display("FAIL wrong_fixed: got OUT=%0d unlocked=%b ledoff=%b want 21 0 1", OUT, unlocked, ledoff);
        end
      end
    end
  endtask

  task automatic test_multi();
    logic [3:0] q[$];
    q = '{4'b0101, 4'b0000, 4'b0010, 4'b1000, 4'b0100};
    repeat (HOLD + 2) q.push_back(4'b0000);
    foreach (q[i]) begin
      cycle(q[i]);
      tests_run++;
      if (observed_out() !== expected_out()) begin
        tests_failed++;
        $display("FAIL multi cycle %0d: got %h want %h", cyc, observed_out(), expected_out());
      end
      if (i == 4) begin
        tests_run++;
        if (OUT !== 5'd21) begin
          tests_failed++;
          $display("FAIL multi_fixed: got OUT=%0d want 21", OUT);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] q[$];
    q = '{4'b0001};
    repeat (TIMEOUT + 1) q.push_back(4'b0000);
    q.push_back(4'b0001); q.push_back(4'b0010); q.push_back(4'b1000); q.push_back(4'b0100);
    repeat (HOLD + 2) q.push_back(4'b0000);
    foreach (q[i]) begin
      cycle(q[i]);
      tests_run++;
      if (observed_out() !== expected_out()) begin
        tests_failed++;
        $display("FAIL timeout cycle %0d: got %h want %h", cyc, observed_out(), expected_out());
      end
      if (i == TIMEOUT - 1 || i == TIMEOUT || i == TIMEOUT + 5) begin
        tests_run++;
        if (OUT !== ((i == TIMEOUT - 1) ? 5'd1 : (i == TIMEOUT) ? 5'd0 : 5'd20)) begin
          tests_failed++;
          $display("FAIL timeout_fixed step %0d: got OUT=%0d", i, OUT);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] q[$];
    cycle(4'b0001); cycle(4'b0010); cycle(4'b1000);
    tests_run++;
    if (OUT !== 5'd3) begin
      tests_failed++;
      $display("FAIL reset_mid_pre: got OUT=%0d want 3", OUT);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (observed_out() !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got %h want 00", observed_out());
    end
    model_reset();
    @(negedge clkin);
    @(negedge clkin);
    reset = 1'b0;
    q = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b0100};
    repeat (HOLD + 2) q.push_back(4'b0000);
    foreach (q[i]) begin
      cycle(q[i]);
      tests_run++;
      if (observed_out() !== expected_out()) begin
        tests_failed++;
        $display("FAIL reset_mid cycle %0d: got %h want %h", cyc, observed_out(), expected_out());
      end
      if (i == 2 || i == 7) begin
        tests_run++;
        if (OUT !== ((i == 2) ? 5'd0 : 5'd20)) begin
          tests_failed++;
          $display("FAIL reset_mid_fixed step %0d: got OUT=%0d", i, OUT);
        end
      end
    end
  endtask

  task automatic test_lockout();
    logic [3:0] q[$];
    for (int s = 0; s < 3; s++) begin
      q = '{4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0100};
      repeat (HOLD + 2) q.push_back(4'b0000);
      foreach (q[i]) begin
        cycle(q[i]);
        tests_run++;
        if (observed_out() !== expected_out()) begin
          tests_failed++;
          $display("FAIL lockout seq%0d cycle %0d: got %h want %h", s, cyc, observed_out(), expected_out());
        end
      end
    end
`ifdef PW_LOCKOUT_EN
    tests_run++;
    if (OUT !== 5'd22 || locked !== 1'b1 || ledoff !== 1'b1) begin
      tests_failed++;
      $display("FAIL lockout_fixed: got OUT=%0d locked=%b ledoff=%b want 22 1 1", OUT, locked, ledoff);
    end
`else
    tests_run++;
    if (OUT !== 5'd0 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL nolock_fixed: got OUT=%0d locked=%b want 0 0", OUT, locked);
    end
`endif
    q = {};
    repeat (LOCKC - 4) q.push_back(4'($urandom));
    repeat (TIMEOUT + 2) q.push_back(4'b0000);
    q.push_back(4'b0001); q.push_back(4'b0010); q.push_back(4'b1000); q.push_back(4'b0100);
    foreach (q[i]) begin
      cycle(q[i]);
      tests_run++;
      if (observed_out() !== expected_out()) begin
        tests_failed++;
        $display("FAIL lockout_tail cycle %0d: got %h want %h", cyc, observed_out(), expected_out());
      end
    end
    tests_run++;
    if (OUT !== 5'd20 || unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL lockout_reopen: got OUT=%0d unlocked=%b want 20 1", OUT, unlocked);
    end
    repeat (HOLD + 1) cycle(4'b0000);
  endtask

  task automatic test_random();
    bit         quiet;
    logic [3:0] lvl;
    quiet = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 64 == 0) quiet = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < (quiet ? 97 : 55)) lvl = 4'b0000;
      else if ($urandom_range(0, 9) < 7) lvl = 4'b0001 << PW[$urandom_range(0, 3)];
      else lvl = 4'($urandom);
      cycle(lvl);
      tests_run++;
      if (observed_out() !== expected_out()) begin
        tests_failed++;
        $display("FAIL random cycle %0d: got %h want %h", cyc, observed_out(), expected_out());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    {d, c, b, a} = 4'b0000;
    model_reset();
    @(negedge clkin);
    @(negedge clkin);
    test_reset();
    test_open();
    test_wrong();
    test_multi();
    test_timeout();
    test_reset_mid();
    test_lockout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pw_entry_fsm.md
PW_ENTRY_FSM -- requirements
Module: pw_entry_fsm

Interface
REQ-001 Parameter PW0, default 2'd0: button index (0=a, 1=b, 2=c, 3=d) expected as the 1st press.
REQ-002 Parameter PW1, default 2'd1: button index expected as the 2nd press.
REQ-003 Parameter PW2, default 2'd3: button index expected as the 3rd press.
REQ-004 Parameter PW3, default 2'd2: button index expected as the 4th press.
REQ-005 Parameter HOLD_CYCLES, default 100_000_000: result display time, in clkin cycles.
REQ-006 Parameter TIMEOUT_CYCLES, default 500_000_000: maximum idle gap allowed between presses during entry.
REQ-007 Parameter LOCK_CYCLES, default 1_000_000_000 and MAX_FAIL, default 3: lockout duration and failure threshold.
REQ-008 clkin  input  1  single clock for the block; all state changes on its rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 a, b, c, d  input  1 each  debounced push-button levels from the debounce filters.
REQ-011 OUT  output  5  character code consumed by the cathode controller.
REQ-012 ledoff  output  1  high while the LED timer must be suppressed.
REQ-013 unlocked  output  1  high for the duration of the OPEN state.
REQ-014 locked  output  1  high for the duration of the LOCK state.

Function
REQ-015 Each button SHALL be rising-edge detected against its registered previous level: press = level & ~prev.
REQ-016 A cycle with one or more presses SHALL count as exactly one entry; if more than one press occurs in that cycle, the entry is a mismatch.
REQ-017 States SHALL be IDLE, ENTRY, OPEN, FAIL and LOCK.
REQ-018 In IDLE, a press SHALL move to ENTRY with digit count 1, and the mismatch flag is set if the press differs from PW0.
REQ-019 In ENTRY, each press SHALL increment the 3-bit digit count and OR (press != PWn) into the mismatch flag.
REQ-020 On the 4th press, the FSM SHALL go to OPEN if the mismatch flag, including the 4th press, is clear; otherwise it goes to FAIL.
REQ-021 Evaluation SHALL always wait for all 4 presses; an early mismatch is never revealed before the 4th press.
REQ-022 In ENTRY, a gap timer SHALL reload on every press; if it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, clearing digit count and mismatch, with no failure counted.
REQ-023 OPEN and FAIL SHALL last exactly HOLD_CYCLES cycles, then return to IDLE.
REQ-024 All presses in OPEN, FAIL and LOCK SHALL be ignored, with no effect on counters.
REQ-025 Entering OPEN SHALL clear the fail counter.
REQ-026 Entering FAIL SHALL increment the fail counter, saturating at MAX_FAIL.
REQ-027 OUT SHALL be registered: IDLE 5'd0; ENTRY = digit count (5'd1..5'd3); OPEN 5'd20; FAIL 5'd21; LOCK 5'd22.
REQ-028 OUT, ledoff, unlocked and locked SHALL change on the clock edge on which the state changes (1-cycle latency from the press edge).
REQ-029 ledoff SHALL be 1 in OPEN, FAIL and LOCK, and 0 otherwise.

Reset
REQ-030 Asserting reset SHALL asynchronously force IDLE, clear the digit count, mismatch flag, all timers, fail counter and edge registers, and set OUT=5'd0 and ledoff=unlocked=locked=0.
REQ-031 Reset mid-entry or mid-lockout SHALL abandon the operation with no residual state.
REQ-032 A button held through reset deassertion SHALL NOT generate a press; edge registers capture the live inputs on the first cycle after reset.

Configuration
REQ-033 With PW_LOCKOUT_EN defined: when FAIL's hold expires with fail counter == MAX_FAIL, the FSM SHALL go to LOCK instead of IDLE, stay for LOCK_CYCLES, then go to IDLE and clear the fail counter.
REQ-034 Without PW_LOCKOUT_EN: the LOCK state, fail counter and lock timer SHALL be absent, locked is tied 0, and FAIL always returns to IDLE.

Verification (HOLD=8, TIMEOUT=20, LOCK=30, MAX_FAIL=3)
REQ-035 Presses a,b,d,c one cycle apart -> OUT 1,2,3 then 20; unlocked=ledoff=1 for 8 cycles; then OUT=0.
REQ-036 Presses b,b,d,c -> OUT 1,2,3 then 21 (FAIL) for 8 cycles; unlocked stays 0.
REQ-037 a and c rising in the same cycle, then b,d,c -> FAIL.
REQ-038 Press a, then 20 idle cycles -> OUT returns to 0; the next correct sequence reaches OPEN; fail counter unchanged.
REQ-039 With PW_LOCKOUT_EN, three wrong sequences -> after the 3rd FAIL, OUT=22 and locked=1 for 30 cycles with presses ignored; then IDLE, and a correct sequence opens.
REQ-040 Reset asserted during the 3rd digit while d is held high -> immediate OUT=0 and no press counted after release of reset.
